// File: rtl/interval_timer.sv
// Programmable interval timer: holds base/extended/yellow durations, prescales clk to a
// 1 s tick and counts the selected duration down. Optional pause input under `TIMER_PAUSE_EN.
module interval_timer #(
    parameter int TICK_DIV   = 100000000,
    parameter int VAL_W      = 4,
    parameter int T_BASE_DEF = 6,
    parameter int T_EXT_DEF  = 3,
    parameter int T_YEL_DEF  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_timer,
    input  logic [2:0]       interval,
    input  logic             Prog_Sync,
    input  logic [1:0]       Time_Param_Sel,
    input  logic [VAL_W-1:0] Time_Value,
`ifdef TIMER_PAUSE_EN
    input  logic             pause,
`endif
    output logic             expired,
    output logic             busy,
    output logic [VAL_W:0]   remaining,
    output logic             one_hz_tick
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]    PRE_MAX  = PW'(TICK_DIV - 1);
    localparam logic [VAL_W-1:0] BASE_DEF = VAL_W'(T_BASE_DEF);
    localparam logic [VAL_W-1:0] EXT_DEF  = VAL_W'(T_EXT_DEF);
    localparam logic [VAL_W-1:0] YEL_DEF  = VAL_W'(T_YEL_DEF);

    typedef enum logic [1:0] {IDLE = 2'd0, COUNT = 2'd1, DONE = 2'd2} state_t;

    state_t           state, state_nx;
    logic [PW-1:0]    presc;
    logic [VAL_W-1:0] t_base, t_ext, t_yel;
    logic [VAL_W:0]   dur;
    logic             hold;
    logic             tick_now;

`ifdef TIMER_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    assign tick_now = (state == COUNT) && !hold && (presc == PRE_MAX);

    // Double base uses the extra bit of dur, so it never overflows.
    always_comb begin
        dur = {1'b0, t_base};
        case (interval)
            3'd1:    dur = {1'b0, t_ext};
            3'd2:    dur = {1'b0, t_yel};
            3'd3:    dur = {t_base, 1'b0};
            default: dur = {1'b0, t_base};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Programming aborts everything; otherwise a start restarts from any state.
    always_comb begin
        state_nx = state;
        if (Prog_Sync) begin
            state_nx = IDLE;
        end else if (start_timer) begin
            state_nx = COUNT;
        end else begin
            case (state)
                COUNT:   if (tick_now && remaining <= (VAL_W+1)'(1)) state_nx = DONE;
                DONE:    state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        busy        = (state == COUNT);
        expired     = (state == DONE);
        one_hz_tick = tick_now;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc     <= '0;
            remaining <= '0;
        end else if (Prog_Sync) begin
            presc     <= '0;
            remaining <= '0;
        end else if (start_timer) begin
            presc     <= '0;
            remaining <= dur;
        end else if (state == COUNT && !hold) begin
            if (tick_now) begin
                presc <= '0;
                if (remaining != '0) remaining <= remaining - 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

    // A zero value restores the slot default so no duration can ever be zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_base <= BASE_DEF;
            t_ext  <= EXT_DEF;
            t_yel  <= YEL_DEF;
        end else if (Prog_Sync) begin
            case (Time_Param_Sel)
                2'd0:    t_base <= (Time_Value == '0) ? BASE_DEF : Time_Value;
                2'd1:    t_ext  <= (Time_Value == '0) ? EXT_DEF  : Time_Value;
                2'd2:    t_yel  <= (Time_Value == '0) ? YEL_DEF  : Time_Value;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/interval_timer.md
Name: interval_timer

Overview:
- Programmable interval timer and parameter store that the traffic-light FSM sequences through start_timer, interval and expired.
- Holds the three programmable durations (base, extended, yellow) and generates the 1 Hz tick internally.
- Loads the duration the FSM selects, counts it down and reports expiry.
- Programming (Prog_Sync) rewrites a duration and aborts any interval in flight.

Parameters:
TICK_DIV, 100000000, clk cycles per 1 s tick (100 MHz clk); benches override with a small value
VAL_W, 4, width of each programmed duration in seconds
T_BASE_DEF, 6, reset/default base duration
T_EXT_DEF, 3, reset/default extended duration
T_YEL_DEF, 2, reset/default yellow duration

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start_timer  in  1  restart request from the FSM; sampled each edge
interval  in  3  duration select: 0 base, 1 extended, 2 yellow, 3 double base; 4-7 treated as base
Prog_Sync  in  1  synchronized program strobe, one cycle
Time_Param_Sel  in  2  slot to program: 0 base, 1 extended, 2 yellow, 3 ignored
Time_Value  in  VAL_W  value to program, in seconds
expired  out  1  one-cycle pulse at the end of an interval
busy  out  1  high while counting
remaining  out  VAL_W+1  seconds left in the current interval
one_hz_tick  out  1  one-cycle tick pulse, visible only while counting

Behaviour:
- Reset (asynchronous, rst_n low):
  - State IDLE; outputs expired=0, busy=0, remaining=0, one_hz_tick=0.
  - Prescaler cleared; parameter registers set to T_BASE_DEF, T_EXT_DEF and T_YEL_DEF.
- Duration select D is computed from interval and zero-extended to VAL_W+1 bits. Interval 3 gives 2*base, with no overflow in VAL_W+1 bits.
- Programming, when Prog_Sync=1 at an edge:
  - Writes Time_Value into the slot chosen by Time_Param_Sel. Time_Value=0 writes that slot's default instead. Sel=3 writes nothing.
  - Forces state to IDLE, clears remaining and the prescaler, and suppresses expired.
  - Takes priority over start_timer in the same cycle.
- State machine (IDLE, COUNT, DONE):
  - IDLE: on start_timer go to COUNT, load remaining=D and prescaler=0.
  - COUNT: busy=1. The prescaler increments each cycle. At TICK_DIV-1 it asserts one_hz_tick for one cycle, wraps to 0 and remaining decrements. On the tick where remaining=1, go to DONE with remaining=0.
  - DONE: expired=1 for exactly this cycle, then IDLE. busy=0.
- start_timer in any state (COUNT or DONE included) reloads D with prescaler 0 and enters COUNT at the next edge.
  - Start together with the terminal tick: the start wins, and no expired pulse is issued for the old interval.
  - Start during DONE: the expired pulse still appears in that DONE cycle.
- Latency: start_timer sampled at edge k gives the load at edge k. expired is high in the cycle after edge k+D*TICK_DIV.
- The parameter registers are read at load time only. Reprogramming does not change an interval already loaded, since programming aborts it anyway.
- expired is never asserted twice without an intervening start_timer.

Optional Feature:
TIMER_PAUSE_EN
- Defined:
  - Adds input port pause (1 bit).
  - While pause=1 in COUNT, the prescaler and remaining hold and one_hz_tick stays 0.
  - start_timer and Prog_Sync still act normally during pause.
- Undefined: no pause port; counting is never held.

Test Plan:
- Reset default base: TICK_DIV=4, reset, interval=0, start_timer pulse at edge 0 -> busy=1, remaining 6,5,...,1 stepping every 4 cycles; expired one-cycle pulse in the cycle after edge 24; busy=0 afterwards.
- Programming: Prog_Sync with Sel=2, Value=5, then interval=2 start -> expiry after 20 cycles. Program Sel=1, Value=0, then interval=1 -> reverts to 3 (12 cycles).
- Double base plus wrap: program base=15, interval=3 -> remaining loads 30 (5-bit) and expired arrives after 120 cycles. interval=6 behaves as base (60 cycles).
- Restart and abort:
  - start_timer again mid-count -> reload, no expired for the first interval.
  - start_timer coincident with the terminal tick -> no pulse for the old interval; new interval runs in full.
  - Prog_Sync mid-count -> IDLE, no expired.
- Async reset mid-count: drop rst_n between edges -> outputs 0 immediately; parameters return to 6/3/2.
- With TIMER_PAUSE_EN defined: pause for 10 cycles mid-interval -> expiry delayed by exactly 10 cycles; one_hz_tick stays 0 during the pause.
